// File: rtl/scu_pipe.sv
// Pipelined sparse compute unit: gather-multiply (S1), per-address scatter-add (S2), tile snapshot to output.
// Optional SCU_PIPE_ROUND_SAT_EN selects round-half-up with saturation for the output field instead of truncation.
module scu_pipe #(
    parameter int A_BITS    = 12,
    parameter int W_BITS    = 16,
    parameter int I_BITS    = 6,
    parameter int LANES     = 18,
    parameter int NUM_OC    = 3,
    parameter int OC_SIZE   = 16,
    parameter int ACT_DEPTH = 36,
    parameter int ACC_BITS  = 32,
    parameter int OUT_SHIFT = 20
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             mode,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             in_last,
    input  logic [LANES*W_BITS-1:0]          weights,
    input  logic [ACT_DEPTH*A_BITS-1:0]      acts,
    input  logic [LANES*I_BITS-1:0]          indexes,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [NUM_OC*OC_SIZE*A_BITS-1:0] out_data,
    output logic                             busy,
    output logic                             err_oob
);

    localparam int NUM_ACC = NUM_OC * OC_SIZE;
    localparam int LPB     = LANES / NUM_OC;
    localparam int PW      = A_BITS + W_BITS;
    localparam int AW      = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;

    localparam logic [1:0] ST_ACC   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_SNAP  = 2'd2;

`ifdef SCU_PIPE_ROUND_SAT_EN
    localparam logic signed [ACC_BITS:0] RND_HALF =
        {{(ACC_BITS+1-OUT_SHIFT){1'b0}}, 1'b1, {(OUT_SHIFT-1){1'b0}}};
    localparam logic signed [ACC_BITS:0] SAT_MAX =
        {{(ACC_BITS+2-A_BITS){1'b0}}, {(A_BITS-1){1'b1}}};
    localparam logic signed [ACC_BITS:0] SAT_MIN =
        {{(ACC_BITS+2-A_BITS){1'b1}}, {(A_BITS-1){1'b0}}};

    function automatic logic signed [A_BITS-1:0] round_sat(input logic signed [ACC_BITS-1:0] a);
        logic signed [ACC_BITS:0] t;
        t = {a[ACC_BITS-1], a} + RND_HALF;
        t = t >>> OUT_SHIFT;
        if (t > SAT_MAX)      return SAT_MAX[A_BITS-1:0];
        else if (t < SAT_MIN) return SAT_MIN[A_BITS-1:0];
        else                  return t[A_BITS-1:0];
    endfunction
`endif

    function automatic logic signed [ACC_BITS-1:0] sext_prod(input logic signed [PW-1:0] p);
        return {{(ACC_BITS-PW){p[PW-1]}}, p};
    endfunction

    logic [1:0]                 state;
    logic                       drain_cnt;
    logic                       accept;
    logic                       snap_fire;
    logic                       pending;

    logic [I_BITS-1:0]          idx_c     [LANES];
    logic signed [W_BITS-1:0]   w_c       [LANES];
    logic signed [A_BITS-1:0]   y_c       [LANES];
    logic [LANES-1:0]           lane_ok_c;
    logic signed [PW-1:0]       prod_c    [LANES];
    logic [AW-1:0]              addr_c    [LANES];

    logic signed [PW-1:0]       prod_p1   [LANES];
    logic [AW-1:0]              addr_p1   [LANES];
    logic                       vld_p1;

    logic signed [ACC_BITS-1:0] sum_s2    [NUM_ACC];
    logic signed [ACC_BITS-1:0] acc_p2    [NUM_ACC];
    logic                       vld_p2;

    logic [NUM_ACC*A_BITS-1:0]  conv_c;

    assign in_ready  = (state == ST_ACC);
    assign accept    = in_valid && in_ready;
    assign snap_fire = (state == ST_SNAP) && (!out_valid || out_ready);
    assign busy      = (state != ST_ACC) || vld_p1 || vld_p2 || pending;

    // ---- S0 -> S1: gather, multiply, destination address ----
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            idx_c[k] = indexes[k*I_BITS +: I_BITS];
            w_c[k]   = weights[k*W_BITS +: W_BITS];
            y_c[k]   = '0;
            for (int a = 0; a < ACT_DEPTH; a++) begin
                if (int'(idx_c[k]) == a) y_c[k] = acts[a*A_BITS +: A_BITS];
            end
            // Out-of-range lanes also cover banked reads beyond OC_SIZE, so their product is forced to 0.
            lane_ok_c[k] = mode ? (int'(idx_c[k]) < OC_SIZE) : (int'(idx_c[k]) < NUM_ACC);
            prod_c[k]    = lane_ok_c[k] ? PW'(y_c[k]) * PW'(w_c[k]) : '0;
            addr_c[k]    = mode ? AW'((k / LPB) * OC_SIZE + int'(idx_c[k])) : AW'(idx_c[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            prod_p1 <= prod_c;
            addr_p1 <= addr_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            err_oob <= 1'b0;
        end else begin
            vld_p1 <= accept;
            if (accept && !(&lane_ok_c)) err_oob <= 1'b1;
        end
    end

    // ---- S1 -> S2: every lane targeting an address is summed before the accumulate ----
    always_comb begin
        for (int j = 0; j < NUM_ACC; j++) begin
            sum_s2[j] = '0;
            for (int k = 0; k < LANES; k++) begin
                if (int'(addr_p1[k]) == j) sum_s2[j] = sum_s2[j] + sext_prod(prod_p1[k]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p2 <= 1'b0;
            for (int j = 0; j < NUM_ACC; j++) acc_p2[j] <= '0;
        end else begin
            vld_p2 <= vld_p1;
            for (int j = 0; j < NUM_ACC; j++) begin
                if (snap_fire)   acc_p2[j] <= '0;
                else if (vld_p1) acc_p2[j] <= acc_p2[j] + sum_s2[j];
            end
        end
    end

    // ---- tile control: accept, drain the pipe, snapshot when the output slot frees ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_ACC;
            drain_cnt <= 1'b0;
            pending   <= 1'b0;
        end else begin
            if (snap_fire)   pending <= 1'b0;
            else if (accept) pending <= 1'b1;
            case (state)
                ST_ACC: begin
                    drain_cnt <= 1'b0;
                    if (accept && in_last) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (!drain_cnt)   drain_cnt <= 1'b1;
                    else if (!vld_p1) state     <= ST_SNAP;
                end
                ST_SNAP: begin
                    if (snap_fire) state <= ST_ACC;
                end
                default: state <= ST_ACC;
            endcase
        end
    end

    // ---- S2 -> output register ----
    always_comb begin
        conv_c = '0;
        for (int j = 0; j < NUM_ACC; j++) begin
`ifdef SCU_PIPE_ROUND_SAT_EN
            conv_c[j*A_BITS +: A_BITS] = round_sat(acc_p2[j]);
`else
            conv_c[j*A_BITS +: A_BITS] = acc_p2[j][OUT_SHIFT +: A_BITS];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (snap_fire) begin
            out_valid <= 1'b1;
            out_data  <= conv_c;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_scu_pipe.sv
// Self-checking bench for scu_pipe: directed cases plus randomized tiles against an arithmetic reference model.
module tb_scu_pipe;

    localparam int A_BITS    = 12;
    localparam int W_BITS    = 16;
    localparam int I_BITS    = 6;
    localparam int LANES     = 18;
    localparam int NUM_OC    = 3;
    localparam int OC_SIZE   = 16;
    localparam int ACT_DEPTH = 36;
    localparam int ACC_BITS  = 32;
    localparam int OUT_SHIFT = 20;
    localparam int NACC      = NUM_OC * OC_SIZE;
    localparam int LPB       = LANES / NUM_OC;
    localparam int OUT_W     = NACC * A_BITS;

    logic                          clk;
    logic                          rst_n;
    logic                          mode;
    logic                          in_valid;
    logic                          in_ready;
    logic                          in_last;
    logic [LANES*W_BITS-1:0]       weights;
    logic [ACT_DEPTH*A_BITS-1:0]   acts;
    logic [LANES*I_BITS-1:0]       indexes;
    logic                          out_valid;
    logic                          out_ready;
    logic [OUT_W-1:0]              out_data;
    logic                          busy;
    logic                          err_oob;

    scu_pipe #(
        .A_BITS(A_BITS), .W_BITS(W_BITS), .I_BITS(I_BITS), .LANES(LANES),
        .NUM_OC(NUM_OC), .OC_SIZE(OC_SIZE), .ACT_DEPTH(ACT_DEPTH),
        .ACC_BITS(ACC_BITS), .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .weights(weights), .acts(acts), .indexes(indexes),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .err_oob(err_oob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: plain integers, wrapped to 32 bits after each add
    int               acc_m [NACC];
    bit               err_m;
    logic [OUT_W-1:0] exp_q [$];
    int               wt [LANES];
    int               ac [ACT_DEPTH];
    int               ix [LANES];

    task automatic chk(input string tag, input logic [OUT_W-1:0] got, input logic [OUT_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [A_BITS-1:0] conv_m(input int a);
`ifdef SCU_PIPE_ROUND_SAT_EN
        longint r;
        r = (longint'(a) + (longint'(1) << (OUT_SHIFT-1))) >>> OUT_SHIFT;
        if (r > 2047)  r = 2047;
        if (r < -2048) r = -2048;
        return A_BITS'(r);
`else
        return A_BITS'(a >>> OUT_SHIFT);
`endif
    endfunction

    function automatic void model_reset();
        for (int j = 0; j < NACC; j++) acc_m[j] = 0;
        err_m = 1'b0;
        exp_q.delete();
    endfunction

    function automatic void model_op(input bit m);
        for (int k = 0; k < LANES; k++) begin
            int     i;
            int     dst;
            longint y;
            i = ix[k];
            if (m ? (i >= OC_SIZE) : (i >= NACC)) begin
                err_m = 1'b1;
                continue;
            end
            y   = (i < ACT_DEPTH) ? longint'(ac[i]) : 0;
            dst = m ? (k / LPB) * OC_SIZE + i : i;
            acc_m[dst] = int'(longint'(acc_m[dst]) + y * longint'(wt[k]));
        end
    endfunction

    function automatic void model_snap();
        logic [OUT_W-1:0] v;
        v = '0;
        for (int j = 0; j < NACC; j++) begin
            v[j*A_BITS +: A_BITS] = conv_m(acc_m[j]);
            acc_m[j] = 0;
        end
        exp_q.push_back(v);
    endfunction

    task automatic drive_arrays();
        for (int k = 0; k < LANES; k++) begin
            weights[k*W_BITS +: W_BITS] = W_BITS'(wt[k]);
            indexes[k*I_BITS +: I_BITS] = I_BITS'(ix[k]);
        end
        for (int a = 0; a < ACT_DEPTH; a++) acts[a*A_BITS +: A_BITS] = A_BITS'(ac[a]);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send_op(input bit m, input bit last);
        int t;
        drive_arrays();
        mode = m; in_last = last; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 1'b0, 1'b1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_op(m);
        if (last) model_snap();
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_out(output bit got);
        int t;
        t = 0;
        while (!out_valid && t < 64) begin
            @(negedge clk);
            t++;
        end
        got = out_valid;
        if (!got) chk("out_timeout", 1'b0, 1'b1);
    endtask

    task automatic check_result(input string tag);
        bit got;
        logic [OUT_W-1:0] e;
        wait_out(got);
        if (!got) return;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        chk(tag, out_data, e);
        chk({tag, "_err"}, err_oob, err_m);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drop"}, out_valid, 1'b0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic rand_lanes(input bit m);
        for (int k = 0; k < LANES; k++) begin
            wt[k] = int'($urandom_range(65535)) - 32768;
            if ($urandom_range(3) == 0) ix[k] = int'($urandom_range(63));
            else                        ix[k] = m ? int'($urandom_range(15)) : int'($urandom_range(47));
        end
        for (int a = 0; a < ACT_DEPTH; a++) ac[a] = int'($urandom_range(4095)) - 2048;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit got;
        rst_n = 1'b0; mode = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        weights = '0; acts = '0; indexes = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready",  in_ready,  1'b1);
        chk("rst_busy",      busy,      1'b0);
        chk("rst_err",       err_oob,   1'b0);
        chk("rst_out_data",  out_data,  '0);

        // Single banked op with a known pattern; output p appears at lanes idx p
        for (int p = 0; p < ACT_DEPTH; p++) ac[p] = (p < 16) ? (p << 6) : 0;
        for (int k = 0; k < LANES; k++) begin
            wt[k] = 1 << 14;
            ix[k] = k % 6;
        end
        send_op(1'b1, 1'b1);
        chk("lat_busy",     busy,     1'b1);
        chk("lat_in_ready", in_ready, 1'b0);
        chk("lat_t1",       out_valid, 1'b0);
        @(negedge clk);
        chk("lat_t2",       out_valid, 1'b0);
        @(negedge clk);
        chk("lat_t3_pre",   out_valid, 1'b0);
        @(negedge clk);
        chk("lat_t3",       out_valid, 1'b1);
        chk("pat_oc1_p3",   out_data[(1*OC_SIZE+3)*A_BITS +: A_BITS], 12'd3);
        chk("pat_oc2_p5",   out_data[(2*OC_SIZE+5)*A_BITS +: A_BITS], 12'd5);
        chk("pat_oc0_p7",   out_data[(0*OC_SIZE+7)*A_BITS +: A_BITS], 12'd0);
        check_result("pattern");

        // Collision: all lanes hit the same flat address and must be summed
        for (int a = 0; a < ACT_DEPTH; a++) ac[a] = (a == 5) ? 1024 : 0;
        for (int k = 0; k < LANES; k++) begin
            wt[k] = 1024;
            ix[k] = 5;
        end
        send_op(1'b0, 1'b1);
        wait_out(got);
        chk("coll_oc0_p5", out_data[5*A_BITS +: A_BITS], 12'd18);
        chk("coll_err",    err_oob, 1'b0);
        check_result("coll");

        // Out-of-range lane in banked mode, then in flat mode
        rand_lanes(1'b1);
        for (int k = 0; k < LANES; k++) ix[k] = int'($urandom_range(15));
        ix[0] = 20;
        send_op(1'b1, 1'b1);
        wait_out(got);
        chk("oob_err_set", err_oob, 1'b1);
        check_result("oob_bank");
        rand_lanes(1'b0);
        for (int k = 0; k < LANES; k++) ix[k] = int'($urandom_range(47));
        ix[7] = 50;
        send_op(1'b0, 1'b1);
        check_result("oob_flat");

        // Backpressure: second tile must wait for the first result to be taken
        rand_lanes(1'b1);
        send_op(1'b1, 1'b1);
        wait_out(got);
        rand_lanes(1'b0);
        send_op(1'b0, 1'b1);
        repeat (6) @(negedge clk);
        chk("bp_in_ready", in_ready,  1'b0);
        chk("bp_busy",     busy,      1'b1);
        chk("bp_valid",    out_valid, 1'b1);
        chk("bp_hold",     out_data,  (exp_q.size() > 0) ? exp_q[0] : '0);
        chk("bp_sticky",   err_oob,   1'b1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_valid2",   out_valid, 1'b1);
        chk("bp_new",      out_data,  (exp_q.size() > 1) ? exp_q[1] : '0);
        void'(exp_q.pop_front());
        void'(exp_q.pop_front());
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_drop",     out_valid, 1'b0);

        // Large accumulator near the positive limit: 4 ops x 18 lanes x 1024 x 29120 = 0x7FF80000
        for (int a = 0; a < ACT_DEPTH; a++) ac[a] = (a == 0) ? 1024 : 0;
        for (int k = 0; k < LANES; k++) begin
            wt[k] = 29120;
            ix[k] = 0;
        end
        for (int i = 0; i < 4; i++) send_op(1'b0, i == 3);
        wait_out(got);
        chk("sat_hi", out_data[0 +: A_BITS], 12'h7FF);
        check_result("sat_hi_model");

        // Half an LSB: 512 x 1024 = 0x00080000
        for (int a = 0; a < ACT_DEPTH; a++) ac[a] = (a == 0) ? 512 : 0;
        for (int k = 0; k < LANES; k++) begin
            wt[k] = (k == 0) ? 1024 : 0;
            ix[k] = 0;
        end
        send_op(1'b0, 1'b1);
        wait_out(got);
`ifdef SCU_PIPE_ROUND_SAT_EN
        chk("half_lsb", out_data[0 +: A_BITS], 12'd1);
`else
        chk("half_lsb", out_data[0 +: A_BITS], 12'd0);
`endif
        check_result("half_lsb_model");

        // Reset while draining discards the tile
        rand_lanes(1'b1);
        send_op(1'b1, 1'b1);
        @(negedge clk);
        pulse_reset();
        chk("rd_out_valid", out_valid, 1'b0);
        chk("rd_busy",      busy,      1'b0);
        chk("rd_in_ready",  in_ready,  1'b1);
        chk("rd_err",       err_oob,   1'b0);
        chk("rd_out_data",  out_data,  '0);
        repeat (4) @(negedge clk);
        chk("rd_no_output", out_valid, 1'b0);
        for (int i = 0; i < 2; i++) begin
            rand_lanes(i[0]);
            for (int k = 0; k < LANES; k++) ix[k] = i[0] ? int'($urandom_range(15)) : int'($urandom_range(47));
            send_op(i[0], i == 1);
        end
        check_result("rd_next_tile");

        // Randomized tiles with mixed modes, gaps and out-of-range lanes
        for (int t = 0; t < 12; t++) begin
            int n;
            n = 1 + int'($urandom_range(3));
            for (int i = 0; i < n; i++) begin
                bit m;
                m = bit'($urandom_range(1));
                rand_lanes(m);
                if ($urandom_range(3) == 0) @(negedge clk);
                send_op(m, i == n - 1);
            end
            repeat ($urandom_range(3)) @(negedge clk);
            check_result($sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
